ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte at a time to the keyboard, for example 0xED LED-set and its argument, or 0xFF reset. It drives the bidirectional PS/2 clock and data lines as open-drain outputs and sits beside the existing PS/2 receiver on the same pins. It performs the full request-to-send sequence, shifts out the frame on device-generated clocks, checks the device ACK, and flags `busy` so the receiver ignores the edges of the transmit frame.

---
 rtl/ps2_defs.sv | 26 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// Shared constants for the PS/2 host transmitter: FSM encoding, error codes,
// common keyboard command bytes and the frame parity helper.
package ps2_defs;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_REQ      = 3'd2;
    localparam logic [2:0] ST_BITS     = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;
    localparam logic [2:0] ST_WAITIDLE = 3'd6;

    localparam logic [1:0] PS2_ERR_NONE    = 2'd0;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] PS2_ERR_NOACK   = 2'd2;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Parity bit that makes the count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a level filter: the output level only
// follows the pin after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int   FILTER_LEN  = 4,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clkk,
    input  logic reset_n,
    input  logic pin,
    output logic level
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] run;

    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_LEVEL;
            sync <= RESET_LEVEL;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

    // run counts consecutive synchronized samples that differ from level.
    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            level <= RESET_LEVEL;
            run   <= '0;
        end else if (sync != level) begin
            if (run == RUN_LAST) begin
                level <= sync;
                run   <= '0;
            end else begin
                run <= run + CW'(1);
            end
        end else begin
            run <= '0;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift-out on the
// device clock, ACK check and watchdog, driving both lines open-drain.
module ps2_host_tx
    import ps2_defs::*;
#(
    parameter int INHIBIT_CYCLES = 2400,
    parameter int TIMEOUT_CYCLES = 360000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clkk,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] debug_state
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);

    logic          clk_lvl;
    logic          dat_lvl;
    logic          clk_lvl_q;
    logic          fall;
    logic [2:0]    state;
    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [WW-1:0] wd_cnt;
    logic [WW-1:0] wd_next;
    logic          wd_active;
    logic          wd_expired;
    logic          accept;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_LEVEL(1'b1)) u_clk_filter (
        .clkk    (clkk),
        .reset_n (reset_n),
        .pin     (ps2_clk_i),
        .level   (clk_lvl)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_LEVEL(1'b1)) u_dat_filter (
        .clkk    (clkk),
        .reset_n (reset_n),
        .pin     (ps2_dat_i),
        .level   (dat_lvl)
    );

    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            clk_lvl_q <= 1'b1;
        end else begin
            clk_lvl_q <= clk_lvl;
        end
    end

    assign fall = clk_lvl_q & ~clk_lvl;

    // Completion cycle keeps tx_ready low so a requester sees done/err first.
    assign busy        = (state != ST_IDLE);
    assign tx_ready    = (state == ST_IDLE) & ~done & ~err;
    assign accept      = tx_valid & tx_ready;
    assign debug_state = state;

    assign wd_active  = (state == ST_BITS) || (state == ST_STOP) ||
                        (state == ST_ACK)  || (state == ST_WAITIDLE);
    assign wd_next    = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + WW'(1);
    assign wd_expired = wd_active & ~fall & (wd_next == WD_LIMIT);

    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (!wd_active || fall) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_next;
        end
    end

    always_ff @(posedge clkk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= PS2_ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (wd_expired) begin
                state      <= ST_IDLE;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                err        <= 1'b1;
                err_code   <= PS2_ERR_TIMEOUT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        if (accept) begin
                            shreg      <= {odd_parity(tx_data), tx_data};
                            err_code   <= PS2_ERR_NONE;
                            inh_cnt    <= '0;
                            ps2_clk_oe <= 1'b1;
                            state      <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            ps2_dat_oe <= 1'b1;
                            inh_cnt    <= '0;
                            state      <= ST_REQ;
                        end else begin
                            inh_cnt <= inh_cnt + IW'(1);
                        end
                    end
                    ST_REQ: begin
                        ps2_clk_oe <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= ST_BITS;
                    end
                    // Each device falling edge presents the next bit, LSB first then parity.
                    ST_BITS: begin
                        if (fall) begin
                            ps2_dat_oe <= ~shreg[0];
                            shreg      <= {1'b1, shreg[8:1]};
                            if (bit_cnt == 4'd8) begin
                                state <= ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (fall) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        if (fall) begin
                            if (dat_lvl) begin
                                err      <= 1'b1;
                                err_code <= PS2_ERR_NOACK;
                                state    <= ST_IDLE;
                            end else begin
                                state <= ST_WAITIDLE;
                            end
                        end
                    end
                    ST_WAITIDLE: begin
                        if (clk_lvl && dat_lvl) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model on open-drain lines, a frame-level
// expectation model and a per-cycle output monitor.
module tb_ps2_host_tx;
    import ps2_defs::*;

    localparam int INH = 2400;
    localparam int TMO = 3000;
    localparam int FLT = 4;
    localparam int H   = 30;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;

    logic       clkk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] debug_state;

    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_err = 0;

    logic [10:0] exp_q[$];
    logic        exp_done = 1'b1;
    logic [1:0]  exp_code = PS2_ERR_NONE;
    logic [10:0] got_word;
    logic [10:0] exp_word;

    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clkk        (clkk),
        .reset_n     (reset_n),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_dat_i   (ps2_dat_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .debug_state (debug_state)
    );

    always #5 clkk = ~clkk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Line image seen by the device on its rising edges: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clkk);
        #1;
    endtask

    // ---------------- per-cycle monitor ----------------
    bit         in_frame = 1'b0;
    bit         accept_pend = 1'b0;
    int         phase = 0;
    int         inh_len = 0;
    int         rel_len = 0;
    logic [1:0] model_code = PS2_ERR_NONE;

    always @(negedge clkk) begin
        if (!reset_n) begin
            check("rst_clk_oe", ps2_clk_oe, 0);
            check("rst_dat_oe", ps2_dat_oe, 0);
            check("rst_busy", busy, 0);
            check("rst_tx_ready", tx_ready, 1);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_err_code", err_code, PS2_ERR_NONE);
            check("rst_state", debug_state, ST_IDLE);
            in_frame    = 1'b0;
            accept_pend = 1'b0;
            model_code  = PS2_ERR_NONE;
        end else begin
            if (done) n_done++;
            if (err) n_err++;
            if (accept_pend) begin
                in_frame   = 1'b1;
                phase      = 0;
                inh_len    = 0;
                rel_len    = 0;
                model_code = PS2_ERR_NONE;
            end
            if (in_frame && (done || err)) begin
                model_code = exp_code;
                check("done_pulse", done, exp_done);
                check("err_pulse", err, !exp_done);
                check("err_code_result", err_code, model_code);
                check("busy_at_end", busy, 0);
                check("tx_ready_at_end", tx_ready, 0);
                if (exp_code == PS2_ERR_TIMEOUT) check("timeout_len", rel_len, TMO);
                in_frame = 1'b0;
            end else if (in_frame) begin
                check("busy", busy, 1);
                check("tx_ready_busy", tx_ready, 0);
                check("err_code_hold", err_code, model_code);
                case (phase)
                    0: begin
                        if (ps2_clk_oe && !ps2_dat_oe) begin
                            inh_len++;
                        end else begin
                            check("inhibit_len", inh_len, INH);
                            check("req_clk_oe", ps2_clk_oe, 1);
                            check("req_dat_oe", ps2_dat_oe, 1);
                            phase = 1;
                        end
                    end
                    1: begin
                        check("clk_release_1cyc", ps2_clk_oe, 0);
                        check("start_bit_held", ps2_dat_oe, 1);
                        rel_len = 1;
                        phase   = 2;
                    end
                    default: begin
                        check("clk_stays_released", ps2_clk_oe, 0);
                        rel_len++;
                    end
                endcase
            end else begin
                check("idle_clk_oe", ps2_clk_oe, 0);
                check("idle_dat_oe", ps2_dat_oe, 0);
                check("idle_busy", busy, 0);
                check("idle_tx_ready", tx_ready, 1);
                check("idle_done", done, 0);
                check("idle_err", err, 0);
                check("idle_err_code", err_code, model_code);
            end
            accept_pend = tx_valid && tx_ready;
            if (accept_pend) exp_q.push_back(frame_of(tx_data));
        end
    end

    // ---------------- device model ----------------
    task automatic device_run(input int mode, output logic [10:0] got);
        bit seen_low = 1'b0;
        bit rts = 1'b0;
        got = '0;
        for (int i = 0; i < INH + 200 && !rts; i++) begin
            if (!ps2_clk_i) seen_low = 1'b1;
            else if (seen_low && !ps2_dat_i) rts = 1'b1;
            if (!rts) tick(1);
        end
        check("rts_seen", rts, 1);
        if (!rts) return;
        got[0] = ps2_dat_i;
        for (int p = 1; p <= 11; p++) begin
            tick(H);
            if (p == 11 && mode == M_ACK) dev_dat = 1'b0;
            tick(3);
            dev_clk = 1'b0;
            tick(H);
            if (p <= 10) got[p] = ps2_dat_i;
            dev_clk = 1'b1;
        end
        tick(5);
        dev_dat = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic wait_ready();
        int i;
        for (i = 0; i < TMO + 500 && !tx_ready; i++) tick(1);
        check("tx_ready_wait", tx_ready, 1);
    endtask

    task automatic send(input logic [7:0] b, input int mode, output logic [10:0] got, output logic [10:0] exp);
        int base;
        exp_done = (mode == M_ACK);
        exp_code = (mode == M_ACK) ? PS2_ERR_NONE : (mode == M_NOACK) ? PS2_ERR_NOACK : PS2_ERR_TIMEOUT;
        wait_ready();
        base = n_done + n_err;
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check("accept_busy", busy, 1);
        if (mode != M_SILENT) device_run(mode, got);
        else got = '0;
        for (int i = 0; i < INH + TMO + 2000; i++) begin
            if (n_done + n_err != base) break;
            tick(1);
        end
        check("completion_seen", n_done + n_err - base, 1);
        check("exp_q_has_frame", exp_q.size() > 0, 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h0;
        tick(2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int e0;

        tick(4);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_clk_oe", ps2_clk_oe, 0);
        reset_n = 1'b1;
        tick(3);

        // 0xED with ACK
        d0 = n_done;
        send(PS2_CMD_SET_LEDS, M_ACK, got_word, exp_word);
        check("ed_bits_literal", got_word, 11'h7DA);
        check("ed_bits_model", got_word, exp_word);
        check("ed_done_once", n_done - d0, 1);
        check("ed_err_code", err_code, PS2_ERR_NONE);

        // parity corners
        send(8'h01, M_ACK, got_word, exp_word);
        check("x01_bits_literal", got_word, 11'h402);
        check("x01_parity", got_word[9], 0);
        check("x01_bits_model", got_word, exp_word);
        send(8'h00, M_ACK, got_word, exp_word);
        check("x00_bits_literal", got_word, 11'h600);
        check("x00_parity", got_word[9], 1);
        check("x00_bits_model", got_word, exp_word);

        // device leaves data high at the ACK clock
        d0 = n_done;
        e0 = n_err;
        send(PS2_CMD_RESET, M_NOACK, got_word, exp_word);
        check("noack_bits_literal", got_word, 11'h7FE);
        check("noack_err_code", err_code, PS2_ERR_NOACK);
        check("noack_no_done", n_done - d0, 0);
        check("noack_err_once", n_err - e0, 1);

        // device never clocks
        send(PS2_CMD_SET_LEDS, M_SILENT, got_word, exp_word);
        check("timeout_err_code", err_code, PS2_ERR_TIMEOUT);
        check("timeout_clk_oe", ps2_clk_oe, 0);
        check("timeout_dat_oe", ps2_dat_oe, 0);
        check("timeout_tx_ready", tx_ready, 1);

        // reset in the middle of the bit phase
        wait_ready();
        tx_data  = PS2_CMD_RESET;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int i = 0; i < INH + 100 && !(ps2_dat_oe && !ps2_clk_oe); i++) tick(1);
        tick(20);
        check("midbits_state", debug_state, ST_BITS);
        check("midbits_start_held", ps2_dat_oe, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_dat_oe", ps2_dat_oe, 0);
        check("async_rst_busy", busy, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        tick(3);
        reset_n = 1'b1;
        tick(3);

        // 0xF4 after reset, with an extra request raised while busy
        d0 = n_done;
        fork
            send(PS2_CMD_ENABLE, M_ACK, got_word, exp_word);
            begin
                tick(INH + 200);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tick(100);
                tx_valid = 1'b0;
            end
        join
        check("f4_bits_literal", got_word, 11'h5E8);
        check("f4_bits_model", got_word, exp_word);
        check("f4_done_once", n_done - d0, 1);
        tick(300);
        check("busy_request_ignored", busy, 0);
        check("no_queued_frame", exp_q.size(), 0);

        check("total_done", n_done, 4);
        check("total_err", n_err, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
